// File: rtl/fifo_flag_buf_if.sv
// Handshake and status bundle between dfcontrol (master) and fifo_flag_buf (slave).
// err_clr exists only when FIFO_ERR_CLR_EN is defined.
interface fifo_flag_buf_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  write;
  logic                  read;
`ifdef FIFO_ERR_CLR_EN
  logic                  err_clr;
`endif
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_empty;
  logic                  Fifo_full;
  logic                  fifo_error;
  logic                  fifo_pause;

`ifdef FIFO_ERR_CLR_EN
  modport master (
    output write, read, err_clr, data_in,
    input  data_out, valid_out, count, almost_full, almost_empty,
           fifo_empty, Fifo_full, fifo_error, fifo_pause
  );
  modport slave (
    input  write, read, err_clr, data_in,
    output data_out, valid_out, count, almost_full, almost_empty,
           fifo_empty, Fifo_full, fifo_error, fifo_pause
  );
`else
  modport master (
    output write, read, data_in,
    input  data_out, valid_out, count, almost_full, almost_empty,
           fifo_empty, Fifo_full, fifo_error, fifo_pause
  );
  modport slave (
    input  write, read, data_in,
    output data_out, valid_out, count, almost_full, almost_empty,
           fifo_empty, Fifo_full, fifo_error, fifo_pause
  );
`endif
endinterface

// File: rtl/fifo_flag_buf.sv
// Single-clock FIFO with registered occupancy flags and hysteretic pause for dfcontrol.
// Optional FIFO_ERR_CLR_EN adds err_clr to clear the sticky fifo_error.
module fifo_flag_buf #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  fifo_flag_buf_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  fifo_empty_q, fifo_empty_d;
  logic                  fifo_full_q, fifo_full_d;
  logic                  fifo_error_q, fifo_error_d;
  logic                  fifo_pause_q, fifo_pause_d;

  logic wr_accept, rd_accept, err_event;

  // Acceptance uses last cycle's registered flags so a write while full is dropped even if a read frees a slot.
  always_comb begin
    wr_accept = bus.write && !fifo_full_q;
    rd_accept = bus.read && !fifo_empty_q;
    err_event = (bus.write && fifo_full_q) || (bus.read && fifo_empty_q);

    wr_ptr_d    = wr_accept ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = rd_accept ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    data_out_d  = rd_accept ? mem_q[rd_ptr_q] : data_out_q;
    valid_out_d = rd_accept;

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    almost_full_d  = (count_d >= AF_LVL);
    almost_empty_d = (count_d <= AE_LVL);
    fifo_empty_d   = (count_d == '0);
    fifo_full_d    = (count_d == FULL_LVL);

`ifdef FIFO_ERR_CLR_EN
    fifo_error_d = err_event || (fifo_error_q && !bus.err_clr);
`else
    fifo_error_d = err_event || fifo_error_q;
`endif

    fifo_pause_d = fifo_pause_q;
    if (count_d >= AF_LVL)      fifo_pause_d = 1'b1;
    else if (count_d <= AE_LVL) fifo_pause_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      valid_out_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      fifo_empty_q   <= 1'b1;
      fifo_full_q    <= 1'b0;
      fifo_error_q   <= 1'b0;
      fifo_pause_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      valid_out_q    <= valid_out_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      fifo_empty_q   <= fifo_empty_d;
      fifo_full_q    <= fifo_full_d;
      fifo_error_q   <= fifo_error_d;
      fifo_pause_q   <= fifo_pause_d;
    end
  end

  // Storage is left unreset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.fifo_empty   = fifo_empty_q;
  assign bus.Fifo_full    = fifo_full_q;
  assign bus.fifo_error   = fifo_error_q;
  assign bus.fifo_pause   = fifo_pause_q;
endmodule

// File: tb/tb_fifo_flag_buf.sv
// Directed self-checking bench for fifo_flag_buf: fill/overflow/drain, wrap-around, pause hysteresis, reset.
module tb_fifo_flag_buf;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fifo_flag_buf_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  fifo_flag_buf #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(3),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic wr, input logic rd, input logic [5:0] din);
    bus.write   = wr;
    bus.read    = rd;
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic ae, input logic af,
                             input logic em, input logic fu, input logic er, input logic pa);
    check_output({tag, ".count"},        32'(bus.count),        32'(cnt));
    check_output({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    check_output({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
    check_output({tag, ".fifo_empty"},   32'(bus.fifo_empty),   32'(em));
    check_output({tag, ".Fifo_full"},    32'(bus.Fifo_full),    32'(fu));
    check_output({tag, ".fifo_error"},   32'(bus.fifo_error),   32'(er));
    check_output({tag, ".fifo_pause"},   32'(bus.fifo_pause),   32'(pa));
  endtask

  task automatic check_data(input string tag, input logic vld, input logic [5:0] dat);
    check_output({tag, ".valid_out"}, 32'(bus.valid_out), 32'(vld));
    check_output({tag, ".data_out"},  32'(bus.data_out),  32'(dat));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
`ifdef FIFO_ERR_CLR_EN
    bus.err_clr = 1'b0;
`endif
    apply_stimulus(1'b0, 1'b0, 6'h00);
    apply_stimulus(1'b0, 1'b0, 6'h00);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 6'h00);
    $display("[TB] reset and idle");
    check_flags("idle", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_data("idle", 1'b0, 6'h00);

    $display("[TB] fill with 0x01..0x08");
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(1'b1, 1'b0, 6'(k));
      check_flags($sformatf("fill%0d", k), k, k <= 2, k >= 6, 1'b0, k == 8, 1'b0, k >= 6);
    end

    $display("[TB] overflow write with concurrent read");
    apply_stimulus(1'b1, 1'b1, 6'h3F);
    check_flags("ovf", 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_data("ovf", 1'b1, 6'h01);

    $display("[TB] drain 0x02..0x08");
    for (int j = 1; j <= 7; j++) begin
      apply_stimulus(1'b0, 1'b1, 6'h00);
      check_flags($sformatf("drain%0d", j), 7 - j, (7 - j) <= 2, (7 - j) >= 6,
                  j == 7, 1'b0, 1'b1, (7 - j) > 2);
      check_data($sformatf("drain%0d", j), 1'b1, 6'(j + 1));
    end
    apply_stimulus(1'b0, 1'b1, 6'h00);
    check_flags("undf", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_data("undf", 1'b0, 6'h08);

    $display("[TB] reset then wrap-around traffic");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 6'h00);
    reset = 1'b1;
    check_flags("rst2", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b1, 1'b0, 6'(8'h0F + k));
      check_flags($sformatf("wpush%0d", k), k, k <= 2, k >= 6, 1'b0, 1'b0, 1'b0, k >= 6);
    end
    for (int j = 1; j <= 6; j++) begin
      apply_stimulus(1'b0, 1'b1, 6'h00);
      check_flags($sformatf("wpop%0d", j), 6 - j, (6 - j) <= 2, (6 - j) >= 6,
                  j == 6, 1'b0, 1'b0, (6 - j) > 2);
      check_data($sformatf("wpop%0d", j), 1'b1, 6'(8'h0F + j));
    end
    apply_stimulus(1'b1, 1'b0, 6'h20);
    check_flags("wrap0", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_data("wrap0", 1'b0, 6'h15);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 6'(8'h21 + i));
      check_flags($sformatf("wrap%0d", i + 1), 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_data($sformatf("wrap%0d", i + 1), 1'b1, 6'(8'h20 + i));
    end
    apply_stimulus(1'b0, 1'b1, 6'h00);
    check_flags("wrapend", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_data("wrapend", 1'b1, 6'h24);
    apply_stimulus(1'b0, 1'b1, 6'h00);
    check_flags("undf2", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_data("undf2", 1'b0, 6'h24);

    $display("[TB] pause hysteresis");
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b1, 1'b0, 6'(8'h2F + k));
      check_flags($sformatf("hpush%0d", k), k, k <= 2, k >= 6, 1'b0, 1'b0, 1'b1, k >= 6);
    end
    apply_stimulus(1'b0, 1'b1, 6'h00);
    check_flags("hpop", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_data("hpop", 1'b1, 6'h30);

    $display("[TB] reset mid-operation");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 6'h00);
    reset = 1'b1;
    check_flags("midrst", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_data("midrst", 1'b0, 6'h00);
    apply_stimulus(1'b0, 1'b1, 6'h00);
    check_flags("postrst", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_data("postrst", 1'b0, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
